// File: rtl/div_pkg.sv
// Shared types and default sizes for the sequential restoring divider.
// The divider control FSM walks IDLE -> RUN -> CHECK -> DONE.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CNT_W  = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/div_step_u.sv
// One combinational restoring-division step: shift a dividend bit into the
// partial remainder, and subtract the divisor when it fits.
module div_step_u #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] rem,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_nxt,
  output logic          q_bit
);

  logic [VW:0] p;

  always_comb begin
    p       = {rem, bit_in};
    q_bit   = (p >= {1'b0, divisor});
    // rem < divisor on entry, so the difference always fits in VW bits
    rem_nxt = q_bit ? VW'(p - {1'b0, divisor}) : p[VW-1:0];
  end

endmodule

// File: rtl/div8u4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with a
// q*d+r self-check that raises err when the result does not reconstruct.
module div8u4_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0,
  output logic          err
);

  localparam int CW = $clog2(DW);
  localparam int PW = DW + VW;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [VW-1:0]   rem_r;
  logic [DW-1:0]   qsh;
  logic [DW-1:0]   dvd_r;
  logic [VW-1:0]   div_r;
  logic [VW-1:0]   rem_nxt;
  logic            q_bit;
  logic            accept;
  logic            mismatch;

  // qsh shifts dividend bits out of the top while quotient bits enter at the bottom
  div_step_u #(.VW(VW)) u_step (
    .rem     (rem_r),
    .bit_in  (qsh[DW-1]),
    .divisor (div_r),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign mismatch  = ((PW'(qsh) * PW'(div_r)) + PW'(rem_r)) != PW'(dvd_r);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN:   if (cnt == '0) state_nxt = CHECK;
      CHECK: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem_r     <= '0;
      qsh       <= '0;
      dvd_r     <= '0;
      div_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_r <= dividend;
            div_r <= divisor;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              div0      <= 1'b1;
              err       <= 1'b0;
            end else begin
              rem_r <= '0;
              qsh   <= dividend;
              cnt   <= CW'(DW - 1);
            end
          end
        end
        RUN: begin
          rem_r <= rem_nxt;
          qsh   <= {qsh[DW-2:0], q_bit};
          cnt   <= cnt - 1'b1;
        end
        CHECK: begin
          quotient  <= qsh;
          remainder <= rem_r;
          div0      <= 1'b0;
          err       <= mismatch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div8u4_seq.sv
// Directed bench for div8u4_seq: vector table, backpressure, mid-run reset,
// fault injection on the quotient register and an exhaustive operand sweep.
module tb_div8u4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div0;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  div8u4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands at the falling edge and leave after the accepting edge (cycle T+1)
  task automatic apply_stimulus(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;

    vecs[0] = '{8'd200, 4'd13, 8'd15,  4'd5,  1'b0, 10};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 10};
    vecs[2] = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0, 10};
    vecs[3] = '{8'd100, 4'd0,  8'd255, 4'd4,  1'b1, 1};
    vecs[4] = '{8'd50,  4'd7,  8'd7,   4'd1,  1'b0, 10};
    vecs[5] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 10};
    vecs[6] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 10};
    vecs[7] = '{8'd15,  4'd0,  8'd255, 4'd15, 1'b1, 1};
    vecs[8] = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0, 10};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset in_ready", 32'(in_ready), 1);
    check_output("reset out_valid", 32'(out_valid), 0);
    check_output("reset quotient", 32'(quotient), 0);
    check_output("reset remainder", 32'(remainder), 0);
    check_output("reset div0", 32'(div0), 0);
    check_output("reset err", 32'(err), 0);

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b);
      wait_result(lat);
      check_output($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check_output($sformatf("vec%0d quotient", i), 32'(quotient), 32'(vecs[i].q));
      check_output($sformatf("vec%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
      check_output($sformatf("vec%0d div0", i), 32'(div0), 32'(vecs[i].z));
      check_output($sformatf("vec%0d err", i), 32'(err), 0);
      check_output($sformatf("vec%0d busy", i), 32'(in_ready), 0);
      take_result();
      check_output($sformatf("vec%0d out_valid drop", i), 32'(out_valid), 0);
      check_output($sformatf("vec%0d in_ready back", i), 32'(in_ready), 1);
    end

    $display("[TB] backpressure");
    apply_stimulus(8'd200, 4'd13);
    wait_result(lat);
    check_output("bp latency", 32'(lat), 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'(i + 1);
      divisor  = 4'd3;
      @(posedge clk);
      #1;
      check_output("bp out_valid", 32'(out_valid), 1);
      check_output("bp in_ready", 32'(in_ready), 0);
      check_output("bp quotient", 32'(quotient), 15);
      check_output("bp remainder", 32'(remainder), 5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("bp release out_valid", 32'(out_valid), 0);
    check_output("bp release in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    check_output("bp no stray accept", 32'(in_ready), 1);

    $display("[TB] reset during RUN");
    apply_stimulus(8'd200, 4'd13);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst in_ready", 32'(in_ready), 1);
    check_output("midrst out_valid", 32'(out_valid), 0);
    check_output("midrst quotient", 32'(quotient), 0);
    check_output("midrst remainder", 32'(remainder), 0);
    check_output("midrst div0", 32'(div0), 0);
    check_output("midrst err", 32'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(8'd50, 4'd7);
    wait_result(lat);
    check_output("midrst next latency", 32'(lat), 10);
    check_output("midrst next quotient", 32'(quotient), 7);
    check_output("midrst next remainder", 32'(remainder), 1);
    take_result();

    $display("[TB] fault injection");
    apply_stimulus(8'd200, 4'd13);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    force dut.qsh = 8'd14;
    @(posedge clk);
    #1;
    release dut.qsh;
    check_output("fault out_valid", 32'(out_valid), 1);
    check_output("fault quotient", 32'(quotient), 14);
    check_output("fault err", 32'(err), 1);
    take_result();

    $display("[TB] exhaustive sweep");
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'hFF;
          er = 4'(a);
          ez = 1'b1;
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
          ez = 1'b0;
        end
        apply_stimulus(8'(a), 4'(b));
        wait_result(lat);
        check_output($sformatf("sweep %0d/%0d {q,r,div0,err,valid}", a, b),
                     32'({quotient, remainder, div0, err, out_valid}),
                     32'({eq, er, ez, 1'b0, 1'b1}));
        take_result();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
